// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 8-bit ALU/accumulator datapath and its
// multi-word sequencer: default widths, ALU opcode encodings and the
// sequencer FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OPCODE_WIDTH = 3;
    localparam int DEF_CNT_WIDTH    = 4;

    // ALU opcodes; the sequencer passes them through untouched.
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_ADD  = 3'd0;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_SUB  = 3'd1;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_AND  = 3'd2;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_OR   = 3'd3;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_XOR  = 3'd4;
    localparam logic [DEF_OPCODE_WIDTH-1:0] OP_PASS = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } mw_state_t;

endpackage

// File: rtl/alu_mw_operand_reg.sv
// ---------------------------------------------------------------------------
// alu_mw_operand_reg
// Operand holding register pair with a common load enable.
//   clk, rst        clock, synchronous active-high reset (clears to 0)
//   load            capture d_0/d_1 on this edge
//   d_0, d_1        operand pair in
//   q_0, q_1        held operand pair out
// ---------------------------------------------------------------------------
module alu_mw_operand_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d_0,
    input  logic [DATA_WIDTH-1:0] d_1,
    output logic [DATA_WIDTH-1:0] q_0,
    output logic [DATA_WIDTH-1:0] q_1
);

    logic [DATA_WIDTH-1:0] hold_0_r;
    logic [DATA_WIDTH-1:0] hold_1_r;

    // Holding registers: load on enable, otherwise keep value.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_0_r <= {DATA_WIDTH{1'b0}};
            hold_1_r <= {DATA_WIDTH{1'b0}};
        end else if (load) begin
            hold_0_r <= d_0;
            hold_1_r <= d_1;
        end
    end

    assign q_0 = hold_0_r;
    assign q_1 = hold_1_r;

endmodule

// File: rtl/alu_mw_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mw_sequencer
// Multi-word arithmetic sequencer for the ALU/accumulator datapath. Takes
// one request (opcode, carry-in, word count), pulls operand pairs LSW first,
// pulses the datapath accumulator enable once per word while chaining the
// registered carry, and streams each result word out.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, req_op, req_cin,   request strobe and parameters (sampled in IDLE;
//   req_words                 word count 0 is treated as 1)
//   busy, done, carry_final   status; done is a one-cycle pulse
//   in_valid/in_ready,        operand pair stream
//   in_data_0, in_data_1
//   out_valid/out_ready,      result word stream
//   out_data, out_last
//   alu_opcode, alu_data_0,   registered datapath controls, qualified by
//   alu_data_1, alu_carry_in  accumulator_ce
//   accumulator_ce
//   acc_data, acc_carry       datapath accumulator and registered carry
//
// Optional build macro: ALU_MW_ZERO_FLAG_EN adds output zero_final, high
// when every result word of the last completed request was zero.
// ---------------------------------------------------------------------------
module alu_mw_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] req_op,
    input  logic                    req_cin,
    input  logic [CNT_WIDTH-1:0]    req_words,
    output logic                    busy,
    output logic                    done,
    output logic                    carry_final,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data_0,
    input  logic [DATA_WIDTH-1:0]   in_data_1,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_last,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [DATA_WIDTH-1:0]   alu_data_0,
    output logic [DATA_WIDTH-1:0]   alu_data_1,
    output logic                    alu_carry_in,
    output logic                    accumulator_ce,
    input  logic [DATA_WIDTH-1:0]   acc_data,
    input  logic                    acc_carry
`ifdef ALU_MW_ZERO_FLAG_EN
    ,
    output logic                    zero_final
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    mw_state_t state_r;
    mw_state_t state_nxt_s;

    logic [OPCODE_WIDTH-1:0] op_r;
    logic [OPCODE_WIDTH-1:0] alu_opcode_r;
    logic                    cin_r;
    logic                    alu_carry_in_r;
    logic                    carry_final_r;
    logic [CNT_WIDTH-1:0]    count_r;
    logic [CNT_WIDTH-1:0]    index_r;

    logic busy_s;
    logic in_ready_s;
    logic out_valid_s;
    logic ce_s;
    logic done_s;
    logic last_s;
    logic fetch_acc_s;
    logic emit_acc_s;

    logic [DATA_WIDTH-1:0] hold_0_s;
    logic [DATA_WIDTH-1:0] hold_1_s;

    assign fetch_acc_s = in_ready_s & in_valid;
    assign emit_acc_s  = out_valid_s & out_ready;
    assign last_s      = (index_r == (count_r - CNT_ONE));

    // Operand pair is captured on FETCH accept so it is stable during EXEC.
    alu_mw_operand_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_operand_reg (
        .clk  (clk),
        .rst  (rst),
        .load (fetch_acc_s),
        .d_0  (in_data_0),
        .d_1  (in_data_1),
        .q_0  (hold_0_s),
        .q_1  (hold_1_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            EXEC: begin
                state_nxt_s = EMIT;
            end
            EMIT: begin
                if (out_ready && last_s) begin
                    state_nxt_s = DONE;
                end else if (out_ready) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM output decode; all outputs come straight from the state register.
    always_comb begin
        busy_s      = 1'b1;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        ce_s        = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE:    busy_s      = 1'b0;
            FETCH:   in_ready_s  = 1'b1;
            EXEC:    ce_s        = 1'b1;
            EMIT:    out_valid_s = 1'b1;
            DONE:    done_s      = 1'b1;
            default: busy_s      = 1'b0;
        endcase
    end

    // Request latch, word index, datapath controls and final carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r           <= {OPCODE_WIDTH{1'b0}};
            cin_r          <= 1'b0;
            count_r        <= CNT_ZERO;
            index_r        <= CNT_ZERO;
            alu_opcode_r   <= {OPCODE_WIDTH{1'b0}};
            alu_carry_in_r <= 1'b0;
            carry_final_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r    <= req_op;
                        cin_r   <= req_cin;
                        count_r <= (req_words == CNT_ZERO) ? CNT_ONE : req_words;
                        index_r <= CNT_ZERO;
                    end
                end
                FETCH: begin
                    // Controls are loaded one edge ahead of EXEC; acc_carry
                    // already holds the previous word's carry at this point.
                    if (in_valid) begin
                        alu_opcode_r   <= op_r;
                        alu_carry_in_r <= (index_r == CNT_ZERO) ? cin_r : acc_carry;
                    end
                end
                EMIT: begin
                    if (out_ready && !last_s) begin
                        index_r <= index_r + CNT_ONE;
                    end
                end
                DONE: begin
                    carry_final_r <= acc_carry;
                end
                default: begin
                    index_r <= index_r;
                end
            endcase
        end
    end

`ifdef ALU_MW_ZERO_FLAG_EN
    logic zero_acc_r;
    logic zero_final_r;

    // Running all-words-zero flag and its latched copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_acc_r   <= 1'b0;
            zero_final_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            zero_acc_r <= 1'b1;
        end else if (emit_acc_s) begin
            zero_acc_r <= zero_acc_r & (acc_data == {DATA_WIDTH{1'b0}});
        end else if (state_r == DONE) begin
            zero_final_r <= zero_acc_r;
        end
    end

    assign zero_final = zero_final_r;
`endif

    assign busy           = busy_s;
    assign done           = done_s;
    assign carry_final    = carry_final_r;
    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_s;
    assign out_data       = out_valid_s ? acc_data : {DATA_WIDTH{1'b0}};
    assign out_last       = out_valid_s & last_s;
    assign alu_opcode     = alu_opcode_r;
    assign alu_data_0     = hold_0_s;
    assign alu_data_1     = hold_1_s;
    assign alu_carry_in   = alu_carry_in_r;
    assign accumulator_ce = ce_s;

    // emit_acc_s only feeds the optional zero flag.
    logic unused_s;
    assign unused_s = emit_acc_s;

endmodule
